// File: rtl/fp_wb_ieee_pack.sv
// fp_wb_ieee_pack: converts flopoco single-precision MAC results to IEEE-754
// and buffers them in a DEPTH-entry FIFO toward the writeback network.
// Optional feature macro: FP_WB_CANON_NAN_EN (canonical NaN output when defined).
module fp_wb_ieee_pack #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned ID_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_done,
  input  logic [33:0]     in_rd,
  input  logic [ID_W-1:0] in_id,
  output logic            in_ack,
  output logic            wb_done,
  output logic [31:0]     wb_rd,
  output logic [ID_W-1:0] wb_id,
  input  logic            wb_ack
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]     data_mem [DEPTH];
  logic [ID_W-1:0] id_mem   [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     conv_rd;
  logic            push;
  logic            pop;

  // flopoco -> IEEE-754 conversion, done before storage so entries are 32 bits
  always_comb begin
    conv_rd = '0;
    unique case (in_rd[33:32])
      2'b00: conv_rd = {in_rd[31], 31'h0};
      2'b01: conv_rd = in_rd[31:0];
      2'b10: conv_rd = {in_rd[31], 8'hFF, 23'h0};
      default: begin
`ifdef FP_WB_CANON_NAN_EN
        conv_rd = 32'h7FC00000;
`else
        conv_rd = {in_rd[31], 8'hFF, 1'b1, in_rd[21:0]};
`endif
      end
    endcase
  end

  // Handshake terms; in_ack depends on registered count only
  always_comb begin
    in_ack  = (count != FULL);
    wb_done = (count != '0);
    push    = in_done & in_ack;
    pop     = wb_done & wb_ack;
    wb_rd   = data_mem[rd_ptr];
    wb_id   = id_mem[rd_ptr];
  end

  // FIFO pointers, occupancy and storage; reset clears every entry at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        id_mem[i]   <= '0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= conv_rd;
        id_mem[wr_ptr]   <= in_id;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_wb_ieee_pack.sv
// Testbench for fp_wb_ieee_pack: queue reference model plus directed literal checks.
module tb_fp_wb_ieee_pack;

  localparam int DEPTH = 2;
  localparam int ID_W  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_done = 1'b0;
  logic [33:0]     in_rd = '0;
  logic [ID_W-1:0] in_id = '0;
  logic            in_ack;
  logic            wb_done;
  logic [31:0]     wb_rd;
  logic [ID_W-1:0] wb_id;
  logic            wb_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  bit model_on = 1'b0;

  fp_wb_ieee_pack #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .in_done(in_done), .in_rd(in_rd), .in_id(in_id),
    .in_ack(in_ack), .wb_done(wb_done), .wb_rd(wb_rd), .wb_id(wb_id), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion written from the exception-code rules
  function automatic logic [31:0] ref_conv(input logic [33:0] r);
    logic [31:0] v;
    case (r[33:32])
      2'b00: v = r[31] ? 32'h80000000 : 32'h0;
      2'b01: v = r[31:0];
      2'b10: v = r[31] ? 32'hFF800000 : 32'h7F800000;
      default: begin
`ifdef FP_WB_CANON_NAN_EN
        v = 32'h7FC00000;
`else
        v = (r[31:0] & 32'h803FFFFF) | 32'h7FC00000;
`endif
      end
    endcase
    return v;
  endfunction

  // Reference FIFO: entries are {id, data}
  logic [ID_W+31:0] q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      bit do_push, do_pop;
      do_push = in_done && (q.size() < DEPTH);
      do_pop  = wb_ack && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({in_id, ref_conv(in_rd)});
    end
  end

  // Per-cycle comparison against the reference model
  always @(negedge clk) begin
    if (model_on && !rst) begin
      check("m_wb_done", wb_done, q.size() != 0);
      check("m_in_ack", in_ack, q.size() != DEPTH);
      if (wb_done && q.size() != 0) begin
        check("m_wb_rd", wb_rd, q[0][31:0]);
        check("m_wb_id", wb_id, q[0][ID_W+31:32]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [33:0] rd, input logic [ID_W-1:0] id);
    in_done = 1'b1; in_rd = rd; in_id = id;
    cyc();
    in_done = 1'b0;
  endtask

  logic [33:0] vec_in [3];
  logic [31:0] vec_out[3];

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_wb_done", wb_done, 0);
    check("rst_in_ack", in_ack, 1);
    check("rst_wb_rd", wb_rd, 0);
    check("rst_wb_id", wb_id, 0);
    cyc();
    rst = 1'b0;
    model_on = 1'b1;

    // 1: single normal value, one-cycle latency
    wb_ack = 1'b1;
    push_one(34'h1_3F800000, 8'd3);
    @(negedge clk);
    check("t1_wb_done", wb_done, 1);
    check("t1_wb_rd", wb_rd, 32'h3F800000);
    check("t1_wb_id", wb_id, 3);
    cyc();
    @(negedge clk);
    check("t1_empty", wb_done, 0);
    cyc();

    // 2: conversion vectors
    vec_in[0] = 34'h0_80000000; vec_out[0] = 32'h80000000;
    vec_in[1] = 34'h2_FFFFFFFF; vec_out[1] = 32'hFF800000;
    vec_in[2] = 34'h3_FF812345;
`ifdef FP_WB_CANON_NAN_EN
    vec_out[2] = 32'h7FC00000;
`else
    vec_out[2] = 32'hFFC12345;
`endif
    for (int i = 0; i < 3; i++) begin
      push_one(vec_in[i], ID_W'(10 + i));
      @(negedge clk);
      check("t2_conv", wb_rd, vec_out[i]);
      cyc();
    end

    // 3: back-pressure, third offer held until space frees
    wb_ack = 1'b0;
    push_one(34'h1_00000001, 8'd1);
    push_one(34'h1_00000002, 8'd2);
    in_done = 1'b1; in_rd = 34'h1_00000003; in_id = 8'd3;
    @(negedge clk);
    check("t3_full_ack", in_ack, 0);
    check("t3_head1", wb_id, 1);
    cyc();
    @(negedge clk);
    check("t3_hold_ack", in_ack, 0);
    check("t3_hold_head", wb_id, 1);
    wb_ack = 1'b1;
    cyc();
    @(negedge clk);
    check("t3_head2", wb_id, 2);
    check("t3_ack_again", in_ack, 1);
    cyc();
    in_done = 1'b0;
    @(negedge clk);
    check("t3_head3", wb_id, 3);
    check("t3_head3_rd", wb_rd, 32'h00000003);
    cyc();
    @(negedge clk);
    check("t3_empty", wb_done, 0);

    // 4: streaming, 20 results through with occupancy one
    for (int i = 0; i < 20; i++) begin
      in_done = 1'b1; in_rd = {2'b01, 32'h40000000 + 32'(i)}; in_id = ID_W'(i);
      cyc();
      @(negedge clk);
      check("t4_id", wb_id, i);
      check("t4_ack", in_ack, 1);
    end
    in_done = 1'b0;
    cyc();
    @(negedge clk);
    check("t4_drain", wb_done, 0);

    // 5: asynchronous reset with two entries held
    wb_ack = 1'b0;
    push_one(34'h1_11111111, 8'd4);
    push_one(34'h1_22222222, 8'd5);
    #2;
    rst = 1'b1;
    #1;
    check("t5_done_async", wb_done, 0);
    check("t5_ack_async", in_ack, 1);
    cyc();
    rst = 1'b0;
    wb_ack = 1'b1;
    push_one(34'h1_3F000000, 8'd7);
    @(negedge clk);
    check("t5_id7", wb_id, 7);
    check("t5_rd7", wb_rd, 32'h3F000000);
    cyc();
    @(negedge clk);
    check("t5_only", wb_done, 0);
    cyc();

    // 6: random traffic, plus in_ack independence from in_done/wb_ack
    for (int i = 0; i < 10000; i++) begin
      in_done = 1'($urandom_range(0, 1));
      wb_ack  = ($urandom_range(0, 3) != 0);
      in_rd   = {2'($urandom_range(0, 3)), 32'($urandom)};
      in_id   = ID_W'($urandom);
      if ((i % 16) == 0) begin
        logic a0;
        @(negedge clk);
        #1;
        a0 = in_ack;
        in_done = ~in_done; wb_ack = ~wb_ack;
        #1;
        check("t6_ack_comb", in_ack, a0);
        in_done = ~in_done; wb_ack = ~wb_ack;
      end
      cyc();
    end
    in_done = 1'b0;
    wb_ack = 1'b1;
    cyc(); cyc(); cyc();
    @(negedge clk);
    check("t6_drain", wb_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
